dds_phase_accum: RTL and testbench

//  DDS phase accumulator; direct upstream feeder of the sine LUT.

---
 rtl/dds_phase_accum.sv | 170 +++++++++++++++++
 tb/tb_dds_phase_accum.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator with wrap-aligned FTW/offset updates and a linear FTW sweep.
// Optional: define PHASE_DITHER_EN to add LFSR dither below the phase LSB.
module dds_phase_accum #(
  parameter int ACC_WIDTH   = 32,
  parameter int PHASE_WIDTH = 10,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   phase_clr,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ACC_WIDTH-1:0]   cfg_ftw,
  input  logic [ACC_WIDTH-1:0]   cfg_poff,
  input  logic                   sweep_start,
  input  logic [ACC_WIDTH-1:0]   sweep_step,
  input  logic [ACC_WIDTH-1:0]   sweep_end_ftw,
  input  logic [DWELL_WIDTH-1:0] sweep_dwell,
  output logic                   sweep_busy,
  output logic                   sweep_done,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   wrap
);

  typedef enum logic [1:0] {IDLE, DWELL, STEP, DONE} state_t;

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   ftw_act, poff_act;
  logic [ACC_WIDTH-1:0]   ftw_sh, poff_sh;
  logic                   pending;
  logic [ACC_WIDTH-1:0]   step_r, end_r;
  logic [DWELL_WIDTH-1:0] dwell_r, cnt, cnt_nxt;

  logic [ACC_WIDTH:0]     acc_sum;
  logic [ACC_WIDTH-1:0]   phase_sum;
  logic [ACC_WIDTH-1:0]   step_nxt;
  logic [ACC_WIDTH-1:0]   sweep_ftw;
  logic                   sweep_load;
  logic                   step_terminal;
  logic                   carry, apply, accept, sweep_go;
  logic                   unused_lsbs;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_act};
  assign carry     = en & ~phase_clr & acc_sum[ACC_WIDTH];
  // A pending shadow lands on the wrap edge so the new tone starts at phase zero.
  assign apply     = pending & (carry | ~en);
  assign accept    = cfg_valid & cfg_ready;
  assign sweep_go  = (state == IDLE) & sweep_start & ~pending;

  assign cfg_ready  = (state == IDLE) & ~pending;
  assign sweep_busy = (state != IDLE);
  assign sweep_done = (state == DONE);

`ifdef PHASE_DITHER_EN
  localparam int DITHER_W = (ACC_WIDTH - PHASE_WIDTH < 16) ? (ACC_WIDTH - PHASE_WIDTH) : 16;
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  lfsr <= 16'hACE1;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign phase_sum = acc + poff_act + ACC_WIDTH'(lfsr[DITHER_W-1:0]);
`else
  assign phase_sum = acc + poff_act;
`endif

  // Bits below the phase LSB are discarded by truncation.
  assign unused_lsbs = ^phase_sum[ACC_WIDTH-PHASE_WIDTH-1:0];

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      phase       <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      phase       <= phase_sum[ACC_WIDTH-1 -: PHASE_WIDTH];
      phase_valid <= en;
      wrap        <= carry;
      if (phase_clr)  acc <= '0;
      else if (en)    acc <= acc_sum[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_act  <= '0;
      poff_act <= '0;
      ftw_sh   <= '0;
      poff_sh  <= '0;
      pending  <= 1'b0;
    end else begin
      if (apply) begin
        ftw_act  <= ftw_sh;
        poff_act <= poff_sh;
        pending  <= 1'b0;
      end else if (sweep_load) begin
        ftw_act  <= sweep_ftw;
      end
      if (accept) begin
        ftw_sh   <= cfg_ftw;
        poff_sh  <= cfg_poff;
        pending  <= 1'b1;
      end
    end
  end

  assign step_nxt      = ftw_act + step_r;
  assign step_terminal = (step_r == '0) ||
                         (step_r[ACC_WIDTH-1] ? (step_nxt <= end_r) : (step_nxt >= end_r));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sweep_load = 1'b0;
    sweep_ftw  = ftw_act;
    case (state)
      IDLE: begin
        if (sweep_go) begin
          state_nxt = DWELL;
          cnt_nxt   = sweep_dwell;
        end
      end
      DWELL: begin
        if (en) begin
          if (cnt == '0) state_nxt = STEP;
          else           cnt_nxt   = cnt - DWELL_WIDTH'(1);
        end
      end
      STEP: begin
        sweep_load = 1'b1;
        if (step_terminal) begin
          sweep_ftw = end_r;
          state_nxt = DONE;
        end else begin
          sweep_ftw = step_nxt;
          cnt_nxt   = dwell_r;
          state_nxt = DWELL;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      step_r  <= '0;
      end_r   <= '0;
      dwell_r <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (sweep_go) begin
        step_r  <= sweep_step;
        end_r   <= sweep_end_ftw;
        dwell_r <= sweep_dwell;
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Self-checking bench for dds_phase_accum: arithmetic reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_dds_phase_accum;
  localparam int AW = 32;
  localparam int PW = 10;
  localparam int DW = 16;
  localparam longint TWO_AW = 64'h1_0000_0000;
  localparam longint PH_LSB = 64'h40_0000;
  localparam longint HALF   = 64'h8000_0000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          en = 1'b0, phase_clr = 1'b0, cfg_valid = 1'b0, sweep_start = 1'b0;
  logic [AW-1:0] cfg_ftw = '0, cfg_poff = '0, sweep_step = '0, sweep_end_ftw = '0;
  logic [DW-1:0] sweep_dwell = '0;
  logic          cfg_ready, sweep_busy, sweep_done, phase_valid, wrap;
  logic [PW-1:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  dds_phase_accum #(.ACC_WIDTH(AW), .PHASE_WIDTH(PW), .DWELL_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phase_clr(phase_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw), .cfg_poff(cfg_poff),
    .sweep_start(sweep_start), .sweep_step(sweep_step), .sweep_end_ftw(sweep_end_ftw),
    .sweep_dwell(sweep_dwell), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .phase(phase), .phase_valid(phase_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: accumulator as plain modular arithmetic, sweep as an en-tick countdown.
  longint m_acc = 0, m_ftw = 0, m_poff = 0, m_sh_ftw = 0, m_sh_poff = 0;
  longint m_step = 0, m_end = 0, m_phase = 0;
  int     m_wait = 0, m_dwell = 0;
  bit     m_pending = 0, m_sweeping = 0, m_at_step = 0, m_done = 0;
  bit     m_pv = 0, m_wrap = 0;

  always @(posedge clk or negedge rst_n) begin : model
    longint sum, nxt;
    bit     carry, pend_before, neg;
    if (!rst_n) begin
      m_acc = 0; m_ftw = 0; m_poff = 0; m_sh_ftw = 0; m_sh_poff = 0;
      m_pending = 0; m_sweeping = 0; m_at_step = 0; m_done = 0;
      m_phase = 0; m_pv = 0; m_wrap = 0; m_wait = 0;
    end else begin
      pend_before = m_pending;
      m_phase = ((m_acc + m_poff) % TWO_AW) / PH_LSB;
      m_pv    = en;
      sum     = m_acc + m_ftw;
      carry   = en && !phase_clr && (sum >= TWO_AW);
      m_wrap  = carry;
      if (phase_clr) m_acc = 0;
      else if (en)   m_acc = sum % TWO_AW;

      if (m_pending && (carry || !en)) begin
        m_ftw = m_sh_ftw; m_poff = m_sh_poff; m_pending = 0;
      end else if (cfg_valid && !m_sweeping && !m_pending) begin
        m_sh_ftw = cfg_ftw; m_sh_poff = cfg_poff; m_pending = 1;
      end

      if (m_done) begin
        m_done = 0; m_sweeping = 0;
      end else if (m_at_step) begin
        nxt = (m_ftw + m_step) % TWO_AW;
        neg = (m_step >= HALF);
        if (m_step == 0 || (!neg && nxt >= m_end) || (neg && nxt <= m_end)) begin
          m_ftw = m_end; m_done = 1;
        end else begin
          m_ftw = nxt; m_wait = m_dwell;
        end
        m_at_step = 0;
      end else if (m_sweeping) begin
        if (en) begin
          if (m_wait == 0) m_at_step = 1;
          else             m_wait--;
        end
      end else if (sweep_start && !pend_before) begin
        m_sweeping = 1; m_wait = sweep_dwell; m_dwell = sweep_dwell;
        m_step = sweep_step; m_end = sweep_end_ftw;
      end
    end
  end

  always @(negedge clk) begin
    check("phase",       phase,       m_phase);
    check("phase_valid", phase_valid, longint'(m_pv));
    check("wrap",        wrap,        longint'(m_wrap));
    check("cfg_ready",   cfg_ready,   longint'(!m_sweeping && !m_pending));
    check("sweep_busy",  sweep_busy,  longint'(m_sweeping));
    check("sweep_done",  sweep_done,  longint'(m_done));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // Reset state
    run(3);
    check("rst_phase", phase, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_busy",  sweep_busy, 0);
    rst_n = 1'b1;

    // 1: constant tuning word, one phase LSB per clock
    cfg_valid = 1; cfg_ftw = 32'h0040_0000; cfg_poff = 0;
    tick();
    check("t1_ready_pending", cfg_ready, 0);
    cfg_valid = 0;
    tick();
    check("t1_ready_applied", cfg_ready, 1);
    en = 1;
    run(1);
    check("t1_pv_first", phase_valid, 1);
    check("t1_phase0",   phase, 0);
    run(4);
    check("t1_phase4",   phase, 4);
    run(1019);
    check("t1_wrap",     wrap, 1);
    check("t1_phase_w",  phase, 1023);

    // 2: config accepted mid-cycle waits for the wrap
    run(101);
    check("t2_phase100", phase, 100);
    cfg_valid = 1; cfg_ftw = 32'h0080_0000; cfg_poff = 0;
    tick();
    cfg_valid = 0;
    check("t2_ready_lo", cfg_ready, 0);
    check("t2_phase101", phase, 101);
    run(921);
    check("t2_still_step1", phase, 1022);
    check("t2_ready_wait",  cfg_ready, 0);
    tick();
    check("t2_wrap",     wrap, 1);
    check("t2_ready_hi", cfg_ready, 1);
    run(3);
    check("t2_step2",    phase, 4);

    // 3: up-sweep, dwell 3
    en = 0; phase_clr = 1; cfg_valid = 1; cfg_ftw = 32'h0040_0000; cfg_poff = 0;
    tick();
    cfg_valid = 0; phase_clr = 0;
    tick();
    sweep_step = 32'h0040_0000; sweep_end_ftw = 32'h0100_0000; sweep_dwell = 3;
    sweep_start = 1; en = 1;
    tick();
    sweep_start = 0;
    check("t3_busy",  sweep_busy, 1);
    check("t3_ready", cfg_ready, 0);
    run(10);
    check("t3_phase_s10", phase, 14);
    run(5);
    check("t3_phase_s15", phase, 28);
    check("t3_done",      sweep_done, 1);
    tick();
    check("t3_phase_s16", phase, 31);
    check("t3_done_off",  sweep_done, 0);
    check("t3_idle",      sweep_busy, 0);
    tick();
    check("t3_phase_end", phase, 35);

    // 4: phase_clr on the wrap edge, with a phase offset
    en = 0; phase_clr = 1; cfg_valid = 1; cfg_ftw = 32'h4000_0000; cfg_poff = 32'h2000_0000;
    tick();
    cfg_valid = 0; phase_clr = 0;
    tick();
    en = 1;
    run(3);
    phase_clr = 1;
    tick();
    phase_clr = 0;
    check("t4_no_wrap", wrap, 0);
    check("t4_phase",   phase, 896);
    tick();
    check("t4_cleared", phase, 128);
    tick();
    check("t4_resume",  phase, 384);

    // 5: async reset mid-dwell
    sweep_step = 32'h0010_0000; sweep_end_ftw = 32'h7FFF_FFFF; sweep_dwell = 20;
    sweep_start = 1;
    tick();
    sweep_start = 0;
    run(5);
    check("t5_busy_pre", sweep_busy, 1);
    rst_n = 0;
    #2;
    check("t5_phase", phase, 0);
    check("t5_pv",    phase_valid, 0);
    check("t5_wrap",  wrap, 0);
    check("t5_busy",  sweep_busy, 0);
    check("t5_ready", cfg_ready, 1);
    tick();
    rst_n = 1;
    tick();
    check("t5_busy_after",  sweep_busy, 0);
    check("t5_ready_after", cfg_ready, 1);

    // 6: en low for 10 clocks mid-dwell
    en = 0; cfg_valid = 1; cfg_ftw = 32'h0040_0000; cfg_poff = 0;
    tick();
    cfg_valid = 0;
    tick();
    sweep_step = 32'h0040_0000; sweep_end_ftw = 32'h0100_0000; sweep_dwell = 3;
    sweep_start = 1; en = 1;
    tick();
    sweep_start = 0;
    run(2);
    check("t6_phase_pre", phase, 2);
    en = 0;
    run(10);
    check("t6_hold",      phase, 3);
    check("t6_pv_lo",     phase_valid, 0);
    check("t6_busy",      sweep_busy, 1);
    en = 1;
    run(5);
    check("t6_resume",    phase, 8);
    run(20);

    // 7: down-sweep with zero dwell, then sweep_start refused while config pending
    sweep_step = 32'hFFC0_0000; sweep_end_ftw = 32'h0040_0000; sweep_dwell = 0;
    sweep_start = 1;
    tick();
    sweep_start = 0;
    run(6);
    check("t7_done", sweep_done, 1);
    tick();
    check("t7_idle", sweep_busy, 0);
    cfg_valid = 1; cfg_ftw = 32'h0080_0000; cfg_poff = 0;
    tick();
    cfg_valid = 0;
    sweep_step = 32'h0040_0000; sweep_end_ftw = 32'h0200_0000; sweep_dwell = 2;
    sweep_start = 1;
    tick();
    sweep_start = 0;
    check("t7_start_ignored", sweep_busy, 0);
    en = 0;
    tick();
    en = 1;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
